// File: rtl/collision_event_handler_if.sv
// ---------------------------------------------------------------------------
// collision_event_handler_if
//
// Groups the signals between the frame-level game logic (collision event
// handler) and its neighbours: the per-pixel collision detector and scan
// counters on the input side, and the bubble-split / arrow-reload /
// character-respawn logic on the output side.
//
// Signal summary (direction seen from the handler, i.e. the slave modport):
//   startOfFrame    in   1-cycle pulse marking the frame boundary
//   newGame         in   1-cycle pulse restarting the game
//   bubbleHitChar   in   per-pixel bubble/character overlap
//   arrowHitBubble  in   per-pixel arrow/bubble overlap
//   pixelX, pixelY  in   current scan position (11 bits each)
//   charHit         out  1-cycle pulse: character lost a life
//   arrowHit        out  1-cycle pulse: arrow struck a bubble this frame
//   hitX, hitY      out  first arrow/bubble pixel of the evaluated frame
//   lives           out  remaining lives
//   score           out  current score (SCORE_W bits)
//   invulnerable    out  high while the character is in post-hit grace
//   gameOver        out  high once lives reach zero
//   fsm_state       out  raw FSM state, for observation only
//
// Handshake semantics: there is no valid/ready back-pressure. Every input is
// sampled on each rising clock edge. charHit and arrowHit are event strobes:
// each is high for exactly one cycle, the cycle after the startOfFrame that
// closed the frame containing the collision, and the consumer must act on
// that cycle. hitX/hitY are valid from the arrowHit cycle until the next
// arrowHit; lives/score/invulnerable/gameOver are levels valid every cycle.
//
// Modports:
//   master  drives the inputs (collision detector / testbench side)
//   slave   the handler itself
// ---------------------------------------------------------------------------
interface collision_event_handler_if #(
  parameter int SCORE_W = 14
);
  logic               startOfFrame;
  logic               newGame;
  logic               bubbleHitChar;
  logic               arrowHitBubble;
  logic [10:0]        pixelX;
  logic [10:0]        pixelY;
  logic               charHit;
  logic               arrowHit;
  logic [10:0]        hitX;
  logic [10:0]        hitY;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic               invulnerable;
  logic               gameOver;
  logic [1:0]         fsm_state;

  modport master (
    output startOfFrame, newGame, bubbleHitChar, arrowHitBubble, pixelX, pixelY,
    input  charHit, arrowHit, hitX, hitY, lives, score, invulnerable, gameOver,
    input  fsm_state
  );

  modport slave (
    input  startOfFrame, newGame, bubbleHitChar, arrowHitBubble, pixelX, pixelY,
    output charHit, arrowHit, hitX, hitY, lives, score, invulnerable, gameOver,
    output fsm_state
  );
endinterface

// File: rtl/collision_event_handler.sv
// ---------------------------------------------------------------------------
// collision_event_handler
//
// Turns per-pixel collision flags into one event per frame. During a frame
// the two collision inputs are OR-ed into sticky flags, and the position of
// the first arrow/bubble pixel is captured. At each startOfFrame the flags
// of the frame just finished are evaluated against the game FSM
// (PLAY / INVULN / GAME_OVER), producing charHit/arrowHit strobes one cycle
// later, and updating lives, score and the invulnerability timer.
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   bus    collision_event_handler_if.slave (see interface header)
//
// Parameters:
//   INIT_LIVES      lives loaded at reset and on newGame (1..7)
//   INVULN_FRAMES   frame boundaries spent invulnerable after a hit (>=1)
//   POINTS_PER_HIT  score added for each frame containing an arrow hit
//   SCORE_W         score width
//   SCORE_MAX       score saturation value (< 2**SCORE_W)
// ---------------------------------------------------------------------------
module collision_event_handler #(
  parameter int INIT_LIVES     = 3,
  parameter int INVULN_FRAMES  = 60,
  parameter int POINTS_PER_HIT = 10,
  parameter int SCORE_W        = 14,
  parameter int SCORE_MAX      = 9999
) (
  input logic                   clk,
  input logic                   reset,
  collision_event_handler_if.slave bus
);

  localparam int TIMER_W = $clog2(INVULN_FRAMES + 1);

  localparam logic [1:0] ST_PLAY      = 2'd0;
  localparam logic [1:0] ST_INVULN    = 2'd1;
  localparam logic [1:0] ST_GAME_OVER = 2'd2;

  logic [1:0]         state;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [TIMER_W-1:0] timer;

  // Flags and capture for the frame currently being scanned.
  logic               char_flag;
  logic               arrow_flag;
  logic [10:0]        cap_x;
  logic [10:0]        cap_y;

  logic               char_hit;
  logic               arrow_hit;
  logic [10:0]        hit_x;
  logic [10:0]        hit_y;

  // Saturating score increment. The sum is one bit wider than the score so
  // that the overflow past SCORE_MAX is visible before the compare.
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_inc;

  always_comb begin
    score_sum = {1'b0, score} + (SCORE_W + 1)'(POINTS_PER_HIT);
    score_inc = score;
    if (score_sum > (SCORE_W + 1)'(SCORE_MAX)) begin
      score_inc = SCORE_W'(SCORE_MAX);
    end else begin
      score_inc = score_sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_PLAY;
      lives      <= 3'(INIT_LIVES);
      score      <= '0;
      timer      <= '0;
      char_flag  <= 1'b0;
      arrow_flag <= 1'b0;
      cap_x      <= '0;
      cap_y      <= '0;
      char_hit   <= 1'b0;
      arrow_hit  <= 1'b0;
      hit_x      <= '0;
      hit_y      <= '0;
    end else begin
      // Strobes are high for one cycle only.
      char_hit  <= 1'b0;
      arrow_hit <= 1'b0;

      if (bus.newGame) begin
        // newGame overrides a coinciding frame boundary: the finished frame
        // is discarded and collision inputs of this cycle are dropped too.
        state      <= ST_PLAY;
        lives      <= 3'(INIT_LIVES);
        score      <= '0;
        timer      <= '0;
        char_flag  <= 1'b0;
        arrow_flag <= 1'b0;
      end else if (bus.startOfFrame) begin
        // Evaluate the frame that just ended.
        case (state)
          ST_PLAY: begin
            if (arrow_flag) begin
              score     <= score_inc;
              arrow_hit <= 1'b1;
              hit_x     <= cap_x;
              hit_y     <= cap_y;
            end
            if (char_flag) begin
              char_hit <= 1'b1;
              if (lives > 3'd1) begin
                lives <= lives - 3'd1;
                timer <= TIMER_W'(INVULN_FRAMES);
                state <= ST_INVULN;
              end else begin
                // Last life: clamp at zero rather than wrapping.
                lives <= 3'd0;
                state <= ST_GAME_OVER;
              end
            end
          end
          ST_INVULN: begin
            // Character collisions are ignored, including on the exit
            // boundary; arrows still score.
            if (arrow_flag) begin
              score     <= score_inc;
              arrow_hit <= 1'b1;
              hit_x     <= cap_x;
              hit_y     <= cap_y;
            end
            timer <= timer - TIMER_W'(1);
            if (timer <= TIMER_W'(1)) begin
              timer <= '0;
              state <= ST_PLAY;
            end
          end
          ST_GAME_OVER: begin
            // Everything frozen until newGame.
          end
          default: begin
            state <= ST_PLAY;
          end
        endcase

        // Inputs on the boundary cycle belong to the new frame.
        char_flag  <= bus.bubbleHitChar;
        arrow_flag <= bus.arrowHitBubble;
        if (bus.arrowHitBubble) begin
          cap_x <= bus.pixelX;
          cap_y <= bus.pixelY;
        end
      end else begin
        char_flag <= char_flag | bus.bubbleHitChar;
        // Only the first arrow pixel of the frame is captured.
        if (bus.arrowHitBubble && !arrow_flag) begin
          cap_x <= bus.pixelX;
          cap_y <= bus.pixelY;
        end
        arrow_flag <= arrow_flag | bus.arrowHitBubble;
      end
    end
  end

  assign bus.charHit      = char_hit;
  assign bus.arrowHit     = arrow_hit;
  assign bus.hitX         = hit_x;
  assign bus.hitY         = hit_y;
  assign bus.lives        = lives;
  assign bus.score        = score;
  assign bus.invulnerable = (state == ST_INVULN);
  assign bus.gameOver     = (state == ST_GAME_OVER);
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_collision_event_handler.sv
// ---------------------------------------------------------------------------
// tb_collision_event_handler
//
// Stimulus tasks drive pixel-level collision inputs and frame boundaries.
// A frame-level reference model records what happened in each frame and
// applies the game rules at every boundary / newGame, pushing the expected
// post-event output snapshot into exp_q. A separate monitor pops and
// compares one snapshot on the cycle after each boundary or newGame, and
// checks that no strobe appears on any other cycle.
// ---------------------------------------------------------------------------
module tb_collision_event_handler;

  localparam int INIT_LIVES     = 3;
  localparam int INVULN_FRAMES  = 60;
  localparam int POINTS_PER_HIT = 10;
  localparam int SCORE_W        = 14;
  localparam int SCORE_MAX      = 9999;
  localparam int EXP_W          = 1 + 1 + 11 + 11 + 3 + SCORE_W + 1 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  collision_event_handler_if #(.SCORE_W(SCORE_W)) bus ();

  collision_event_handler #(
    .INIT_LIVES    (INIT_LIVES),
    .INVULN_FRAMES (INVULN_FRAMES),
    .POINTS_PER_HIT(POINTS_PER_HIT),
    .SCORE_W       (SCORE_W),
    .SCORE_MAX     (SCORE_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: game state
  int m_lives, m_score, m_inv_left, m_hx, m_hy;
  bit m_over;
  // Reference model: what has happened in the frame being scanned
  bit acc_char, acc_arrow;
  int acc_x, acc_y;

  function automatic logic [EXP_W-1:0] pack(bit c, bit a, int hx, int hy,
                                             int lv, int sc, bit inv, bit over);
    return {c, a, 11'(hx), 11'(hy), 3'(lv), SCORE_W'(sc), inv, over};
  endfunction

  function automatic logic [EXP_W-1:0] dut_snapshot();
    return {bus.charHit, bus.arrowHit, bus.hitX, bus.hitY, bus.lives,
            bus.score, bus.invulnerable, bus.gameOver};
  endfunction

  task automatic report(input string name, input logic [EXP_W-1:0] got,
                        input logic [EXP_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got charHit=%0b arrowHit=%0b hit=(%0d,%0d) lives=%0d score=%0d inv=%0b over=%0b; expected charHit=%0b arrowHit=%0b hit=(%0d,%0d) lives=%0d score=%0d inv=%0b over=%0b",
               name, $time,
               got[EXP_W-1], got[EXP_W-2], got[EXP_W-3 -: 11], got[EXP_W-14 -: 11],
               got[SCORE_W+4 -: 3], got[SCORE_W+1 -: SCORE_W], got[1], got[0],
               exp[EXP_W-1], exp[EXP_W-2], exp[EXP_W-3 -: 11], exp[EXP_W-14 -: 11],
               exp[SCORE_W+4 -: 3], exp[SCORE_W+1 -: SCORE_W], exp[1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_lives = INIT_LIVES; m_score = 0; m_inv_left = 0; m_over = 0;
    m_hx = 0; m_hy = 0;
    acc_char = 0; acc_arrow = 0; acc_x = 0; acc_y = 0;
  endtask

  // ---------------- driver ----------------
  // One clock cycle of stimulus plus the model's view of what that cycle does.
  task automatic drive_cycle(input bit sof, input bit ng, input bit bc,
                             input bit ab, input int x, input int y);
    bit ec, ea;
    @(negedge clk);
    bus.startOfFrame   = sof;
    bus.newGame        = ng;
    bus.bubbleHitChar  = bc;
    bus.arrowHitBubble = ab;
    bus.pixelX         = 11'(x);
    bus.pixelY         = 11'(y);
    ec = 0; ea = 0;
    if (ng) begin
      m_lives = INIT_LIVES; m_score = 0; m_inv_left = 0; m_over = 0;
      acc_char = 0; acc_arrow = 0;
      exp_q.push_back(pack(0, 0, m_hx, m_hy, m_lives, m_score, 0, 0));
    end else if (sof) begin
      if (!m_over) begin
        if (acc_arrow) begin
          ea = 1;
          m_score = (m_score + POINTS_PER_HIT > SCORE_MAX) ? SCORE_MAX
                                                           : m_score + POINTS_PER_HIT;
          m_hx = acc_x; m_hy = acc_y;
        end
        if (m_inv_left > 0) begin
          m_inv_left--;
        end else if (acc_char) begin
          ec = 1;
          if (m_lives > 1) begin
            m_lives--;
            m_inv_left = INVULN_FRAMES;
          end else begin
            m_lives = 0;
            m_over  = 1;
          end
        end
      end
      exp_q.push_back(pack(ec, ea, m_hx, m_hy, m_lives, m_score,
                           m_inv_left > 0, m_over));
      acc_char  = bc;
      acc_arrow = ab;
      if (ab) begin acc_x = x; acc_y = y; end
    end else begin
      acc_char = acc_char | bc;
      if (ab && !acc_arrow) begin acc_x = x; acc_y = y; end
      acc_arrow = acc_arrow | ab;
    end
  endtask

  task automatic idle_cycles(input int n, input int pc, input int pa);
    for (int i = 0; i < n; i++) begin
      drive_cycle(0, 0, $urandom_range(99) < pc, $urandom_range(99) < pa,
                  $urandom_range(2047), $urandom_range(2047));
    end
  endtask

  task automatic boundary(input bit bc, input bit ab);
    drive_cycle(1, 0, bc, ab, $urandom_range(2047), $urandom_range(2047));
  endtask

  // A frame of random pixels closed by a boundary; with bnd_hits the
  // boundary cycle itself may also carry random collisions.
  task automatic rand_frame(input int len, input int pc, input int pa,
                            input bit bnd_hits);
    idle_cycles(len, pc, pa);
    if (bnd_hits) boundary($urandom_range(99) < pc, $urandom_range(99) < pa);
    else          boundary(0, 0);
  endtask

  // ---------------- monitor ----------------
  logic sof_d, ng_d;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sof_d <= 1'b0;
      ng_d  <= 1'b0;
    end else begin
      sof_d <= bus.startOfFrame;
      ng_d  <= bus.newGame;
    end
  end

  initial begin
    logic [EXP_W-1:0] exp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sof_d || ng_d) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL event: DUT event cycle @%0t with empty expected queue", $time);
          end else begin
            exp = exp_q.pop_front();
            report("event", dut_snapshot(), exp);
          end
        end else begin
          checks++;
          if (bus.charHit !== 1'b0 || bus.arrowHit !== 1'b0) begin
            errors++;
            $display("FAIL stray_pulse @%0t: got charHit=%0b arrowHit=%0b, expected 0 0",
                     $time, bus.charHit, bus.arrowHit);
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int wait_cnt;
    reset = 1'b1;
    bus.startOfFrame = 0; bus.newGame = 0; bus.bubbleHitChar = 0;
    bus.arrowHitBubble = 0; bus.pixelX = '0; bus.pixelY = '0;
    model_reset();
    #23;
    report("reset_values", dut_snapshot(), pack(0, 0, 0, 0, INIT_LIVES, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    // Arrow hits at (200,150) then (210,150): first one is captured.
    drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 200, 150);
    drive_cycle(0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 210, 150);
    boundary(0, 0);
    idle_cycles(3, 0, 0);

    // Five char pixels in PLAY -> one life lost, then 60 invulnerable frames
    // full of char hits.
    for (int i = 0; i < 5; i++) drive_cycle(0, 0, 1, 0, 100 + i, 50);
    boundary(0, 0);
    for (int f = 0; f < INVULN_FRAMES; f++) rand_frame($urandom_range(2, 6), 60, 30, 0);

    // Down to one life, wait out invulnerability, then char+arrow together.
    idle_cycles(2, 100, 0);
    boundary(0, 0);
    for (int f = 0; f < INVULN_FRAMES; f++) rand_frame($urandom_range(2, 5), 50, 20, 0);
    drive_cycle(0, 0, 1, 0, 0, 0);
    drive_cycle(0, 0, 0, 1, 321, 123);
    boundary(0, 0);
    for (int f = 0; f < 3; f++) rand_frame(4, 70, 70, 1);
    drive_cycle(0, 1, 0, 0, 0, 0);
    idle_cycles(2, 0, 0);

    // Score saturation: 999 arrow frames reach 9990, the next saturates.
    for (int f = 0; f < 1003; f++) begin
      drive_cycle(0, 0, 0, 1, $urandom_range(2047), $urandom_range(2047));
      boundary(0, 0);
    end

    // Arrow only on the boundary cycle belongs to the next frame.
    idle_cycles(3, 0, 0);
    drive_cycle(1, 0, 0, 1, 77, 88);
    idle_cycles(3, 0, 0);
    boundary(0, 0);

    // Char-hit frame closed by newGame coinciding with startOfFrame.
    idle_cycles(2, 0, 0);
    drive_cycle(0, 0, 1, 0, 0, 0);
    drive_cycle(1, 1, 1, 1, 5, 6);
    idle_cycles(2, 0, 0);
    boundary(0, 0);

    // Randomized mix, with occasional standalone newGame.
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(19) == 0) drive_cycle(0, 1, 0, 0, 0, 0);
      rand_frame($urandom_range(1, 8), 15, 20, 1);
    end

    // Asynchronous reset mid-frame.
    idle_cycles(5, 50, 50);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 report("async_reset", dut_snapshot(), pack(0, 0, 0, 0, INIT_LIVES, 0, 0, 0));
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_at_reset: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    model_reset();
    bus.startOfFrame = 0; bus.newGame = 0; bus.bubbleHitChar = 0;
    bus.arrowHitBubble = 0;
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(3, 0, 0);
    boundary(0, 0);
    drive_cycle(0, 0, 0, 1, 1500, 900);
    boundary(0, 0);
    idle_cycles(2, 0, 0);

    // Drain with a bound.
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d events still pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
